checkout_controller: RTL

Sequential controller for one checkout lane's scan path. Accepts scanned items one at a time over a valid/ready handshake and classifies each from its product-code bits {U,P,C} and security mark M. Keeps per-transaction tallies of items, discounts and stolen items. Halts the lane in an alarm state until a clerk acknowledges any stolen item. Sits between the scanner front end and the register/display logic.

---
 rtl/checkout_pkg.sv | 20 ++
 rtl/checkout_controller_if.sv | 12 +
 rtl/item_classifier.sv | 13 +
 rtl/checkout_controller.sv | 105 ++++++++++
 4 files changed

// File: rtl/checkout_pkg.sv
// rtl/checkout_pkg.sv - shared types and defaults for the checkout lane controller
package checkout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ALARM = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic u;
    logic p;
    logic c;
    logic m;
  } item_t;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/checkout_controller_if.sv
// rtl/checkout_controller_if.sv - scanner item handshake bundle
interface checkout_controller_if;

  logic       item_valid;
  logic       item_ready;
  logic [2:0] item_upc;
  logic       item_mark;

  modport master (output item_valid, output item_upc, output item_mark, input item_ready);
  modport slave  (input item_valid, input item_upc, input item_mark, output item_ready);

endinterface

// File: rtl/item_classifier.sv
// rtl/item_classifier.sv - combinational discount/stolen decode of one scanned item
module item_classifier
  import checkout_pkg::*;
(
  input  item_t item,
  output logic  d,
  output logic  s
);

  assign d = item.p | (item.u & item.c);
  assign s = (~item.p & ~item.c & ~item.m) | (item.u & ~item.p & ~item.m);

endmodule

// File: rtl/checkout_controller.sv
// rtl/checkout_controller.sv - checkout lane scan controller; COUNT_SAT_EN selects saturating tallies
module checkout_controller
  import checkout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  ack,
  checkout_controller_if.slave  item_bus,
  output logic                  busy,
  output logic                  alarm,
  output logic                  discount,
  output logic                  done,
  output logic [CNT_W-1:0]      item_cnt,
  output logic [CNT_W-1:0]      disc_cnt,
  output logic [CNT_W-1:0]      stolen_cnt
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SCAN  = SCAN;
  localparam logic [1:0] S_ALARM = ALARM;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0] state;
  logic       finish_pend;
  logic       item_ready;
  logic       accept;
  logic       cls_d;
  logic       cls_s;
  item_t      item;

  assign item = {item_bus.item_upc, item_bus.item_mark};

  item_classifier u_classifier (
    .item (item),
    .d    (cls_d),
    .s    (cls_s)
  );

  assign item_ready          = (state == S_SCAN);
  assign item_bus.item_ready = item_ready;
  assign busy                = (state != S_IDLE);
  assign alarm               = (state == S_ALARM);
  assign done                = (state == S_DONE);
  assign accept              = item_bus.item_valid & item_ready;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef COUNT_SAT_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      finish_pend <= 1'b0;
      discount    <= 1'b0;
      item_cnt    <= '0;
      disc_cnt    <= '0;
      stolen_cnt  <= '0;
    end else begin
      discount <= accept & cls_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            item_cnt    <= '0;
            disc_cnt    <= '0;
            stolen_cnt  <= '0;
            finish_pend <= 1'b0;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (accept) begin
            item_cnt <= bump(item_cnt);
            if (cls_d) disc_cnt <= bump(disc_cnt);
            if (cls_s) stolen_cnt <= bump(stolen_cnt);
          end
          // A stolen item wins over finish; the finish is remembered for after the ack.
          if (accept && cls_s) begin
            finish_pend <= finish;
            state       <= S_ALARM;
          end else if (finish) begin
            state <= S_DONE;
          end
        end
        S_ALARM: begin
          if (ack) begin
            state <= (finish_pend | finish) ? S_DONE : S_SCAN;
          end else if (finish) begin
            finish_pend <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
